// File: rtl/cu_micro_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cu_micro_seq
//  Purpose  : Microprogram sequencer with writable control store, two opcode
//             dispatch tables and a microsubroutine return stack.
//
//  Ports    :
//    clk       in   1             system clock, rising edge
//    rst_n     in   1             asynchronous active-low reset
//    opcode    in   OP_W          instruction opcode, indexes dispatch tables
//    zero      in   1             ALU zero flag, consumed by BRZ
//    stall     in   1             hold CMAR and return stack
//    uc_we     in   1             microcode load write enable
//    uc_sel    in   2             load target: 0 store, 1 disp1, 2 disp2
//    uc_addr   in   max(AW,OP_W)  load address (truncated per array)
//    uc_wdata  in   CTRL_W+AW+3   load data (dispatch uses [AW-1:0])
//    ctrl      out  CTRL_W        control field of current microword
//    cmar      out  AW            current micro-address
//    sp        out  4             return-stack occupancy
//    err       out  1             sticky stack error
//
//  Revision : 1.0 - initial release
// ============================================================================
module cu_micro_seq #(
  parameter int AW         = 6,
  parameter int CTRL_W     = 24,
  parameter int OP_W       = 6,
  parameter int STK_D      = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [OP_W-1:0]                    opcode,
  input  logic                               zero,
  input  logic                               stall,
  input  logic                               uc_we,
  input  logic [1:0]                         uc_sel,
  input  logic [((AW > OP_W) ? AW : OP_W)-1:0] uc_addr,
  input  logic [CTRL_W+AW+2:0]               uc_wdata,
  output logic [CTRL_W-1:0]                  ctrl,
  output logic [AW-1:0]                      cmar,
  output logic [3:0]                         sp,
  output logic                               err
);

  localparam int WD    = CTRL_W + AW + 3;
  localparam int DEPTH = 1 << AW;
  localparam int OPN   = 1 << OP_W;

  localparam logic [AW-1:0] C_RESET_ADDR = AW'(RESET_ADDR);
  localparam logic [3:0]    C_STK_D      = 4'(STK_D);

  // Sequencing field encoding of each microword
  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'd0,
    SEQ_FETCH = 3'd1,
    SEQ_DISP1 = 3'd2,
    SEQ_DISP2 = 3'd3,
    SEQ_JUMP  = 3'd4,
    SEQ_BRZ   = 3'd5,
    SEQ_CALL  = 3'd6,
    SEQ_RET   = 3'd7
  } seq_e;

  // Storage arrays: not reset, contents survive rst_n
  logic [WD-1:0] r_store [DEPTH];
  logic [AW-1:0] r_disp1 [OPN];
  logic [AW-1:0] r_disp2 [OPN];
  // Sized for the maximum depth of 8 so a 3-bit index always fits;
  // entries at or above STK_D are never written.
  logic [AW-1:0] r_stk   [8];

  logic [AW-1:0] r_cmar;
  logic [3:0]    r_sp;
  logic          r_err;

  logic [WD-1:0] w_word;
  logic [AW-1:0] w_target;
  seq_e          w_seq;
  logic [AW-1:0] w_cmar_inc;
  logic [2:0]    w_pop_idx;
  logic [AW-1:0] w_cmar_nx;
  logic [3:0]    w_sp_nx;
  logic          w_err_nx;
  logic          w_push;

  // --------------------------------------------------------------------------
  // Current microword decode
  // --------------------------------------------------------------------------
  assign w_word     = r_store[r_cmar];
  assign w_target   = w_word[3 +: AW];
  assign w_seq      = seq_e'(w_word[2:0]);
  assign w_cmar_inc = r_cmar + AW'(1);
  // Top-of-stack lives at sp-1; with sp = 8 the 3-bit wrap yields 7.
  assign w_pop_idx  = r_sp[2:0] - 3'd1;

  assign ctrl = w_word[WD-1 -: CTRL_W];
  assign cmar = r_cmar;
  assign sp   = r_sp;
  assign err  = r_err;

  // --------------------------------------------------------------------------
  // Next-address selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_cmar_nx = r_cmar;
    w_sp_nx   = r_sp;
    w_err_nx  = r_err;
    w_push    = 1'b0;
    if (!stall && !r_err) begin
      case (w_seq)
        SEQ_NEXT:  w_cmar_nx = w_cmar_inc;
        SEQ_FETCH: w_cmar_nx = C_RESET_ADDR;
        SEQ_DISP1: w_cmar_nx = r_disp1[opcode];
        SEQ_DISP2: w_cmar_nx = r_disp2[opcode];
        SEQ_JUMP:  w_cmar_nx = w_target;
        SEQ_BRZ:   w_cmar_nx = zero ? w_target : w_cmar_inc;
        SEQ_CALL: begin
          if (r_sp >= C_STK_D) begin
            // Overflow: refuse the push and freeze at the CALL word
            w_err_nx = 1'b1;
          end else begin
            w_push    = 1'b1;
            w_sp_nx   = r_sp + 4'd1;
            w_cmar_nx = w_target;
          end
        end
        SEQ_RET: begin
          if (r_sp == 4'd0) begin
            w_err_nx  = 1'b1;
            w_cmar_nx = C_RESET_ADDR;
          end else begin
            w_sp_nx   = r_sp - 4'd1;
            w_cmar_nx = r_stk[w_pop_idx];
          end
        end
        default: w_cmar_nx = r_cmar;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmar <= C_RESET_ADDR;
      r_sp   <= 4'd0;
      r_err  <= 1'b0;
    end else begin
      r_cmar <= w_cmar_nx;
      r_sp   <= w_sp_nx;
      r_err  <= w_err_nx;
    end
  end

  // Return-address push; the pop path only reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stk[r_sp[2:0]] <= w_cmar_inc;
    end
  end

  // --------------------------------------------------------------------------
  // Microcode load port: independent of stall, err and reset.
  // Dispatch reads above see the pre-edge table contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (uc_we) begin
      case (uc_sel)
        2'd0:    r_store[uc_addr[AW-1:0]]   <= uc_wdata;
        2'd1:    r_disp1[uc_addr[OP_W-1:0]] <= uc_wdata[AW-1:0];
        2'd2:    r_disp2[uc_addr[OP_W-1:0]] <= uc_wdata[AW-1:0];
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cu_micro_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cu_micro_seq
//  Purpose  : Self-checking bench for cu_micro_seq: directed scenarios plus a
//             randomized phase against a behavioural model and scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cu_micro_seq;

  localparam int AW     = 6;
  localparam int CTRL_W = 24;
  localparam int OP_W   = 6;
  localparam int STK_D  = 4;
  localparam int WD     = CTRL_W + AW + 3;
  localparam int DEPTH  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          zero;
  logic          stall;
  logic          uc_we;
  logic [1:0]    uc_sel;
  logic [5:0]    uc_addr;
  logic [WD-1:0] uc_wdata;
  logic [23:0]   ctrl;
  logic [5:0]    cmar;
  logic [3:0]    sp;
  logic          err;

  always #5 clk = ~clk;

  cu_micro_seq #(
    .AW(AW), .CTRL_W(CTRL_W), .OP_W(OP_W), .STK_D(STK_D), .RESET_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .stall(stall),
    .uc_we(uc_we), .uc_sel(uc_sel), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .ctrl(ctrl), .cmar(cmar), .sp(sp), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          cmar;
    int          sp;
    int          err;
    bit          ctrl_ok;
    logic [23:0] ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Behavioural model state
  logic [WD-1:0] m_store [DEPTH];
  bit            m_known [DEPTH];
  int            m_d1    [DEPTH];
  int            m_d2    [DEPTH];
  int            m_stk[$];
  int            m_cmar;
  int            m_err;

  function automatic logic [WD-1:0] mk(int c, int t, int s);
    return {c[23:0], t[5:0], s[2:0]};
  endfunction

  task automatic check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmar = 0;
    m_err  = 0;
    m_stk.delete();
  endtask

  // Predicts the architectural state right after the coming rising edge
  task automatic model_edge();
    int            nc;
    logic [WD-1:0] w;
    int            tgt;
    int            sq;
    exp_t          x;
    nc = m_cmar;
    if (!rst_n) begin
      model_reset();
      nc = 0;
    end else if (!stall && m_err == 0) begin
      w   = m_store[m_cmar];
      tgt = int'(w[8:3]);
      sq  = int'(w[2:0]);
      case (sq)
        0: nc = (m_cmar + 1) % DEPTH;
        1: nc = 0;
        2: nc = m_d1[opcode];
        3: nc = m_d2[opcode];
        4: nc = tgt;
        5: nc = zero ? tgt : (m_cmar + 1) % DEPTH;
        6: begin
          if (m_stk.size() == STK_D) m_err = 1;
          else begin
            m_stk.push_back((m_cmar + 1) % DEPTH);
            nc = tgt;
          end
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_err = 1;
            nc    = 0;
          end else nc = m_stk.pop_back();
        end
      endcase
    end
    if (uc_we) begin
      case (uc_sel)
        2'd0: begin m_store[uc_addr] = uc_wdata; m_known[uc_addr] = 1'b1; end
        2'd1: m_d1[uc_addr] = int'(uc_wdata[5:0]);
        2'd2: m_d2[uc_addr] = int'(uc_wdata[5:0]);
        default: ;
      endcase
    end
    m_cmar    = nc;
    x.cmar    = m_cmar;
    x.sp      = m_stk.size();
    x.err     = m_err;
    x.ctrl_ok = m_known[m_cmar];
    x.ctrl    = m_store[m_cmar][32:9];
    sb.push_back(x);
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] sel, input logic [5:0] a, input logic [WD-1:0] d);
    uc_we    = 1'b1;
    uc_sel   = sel;
    uc_addr  = a;
    uc_wdata = d;
    tick();
    uc_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
  endtask

  // Monitor: compare DUT against the oldest prediction after every edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_cmar", int'(cmar), e.cmar);
      check("sb_sp",   int'(sp),   e.sp);
      check("sb_err",  int'(err),  e.err);
      if (e.ctrl_ok) check("sb_ctrl", int'(ctrl), int'(e.ctrl));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; opcode = '0; zero = 1'b0; stall = 1'b0;
    uc_we = 1'b0; uc_sel = '0; uc_addr = '0; uc_wdata = '0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 1'b0; m_d1[i] = 0; m_d2[i] = 0;
    end
    @(negedge clk);

    // Fill store with NEXT words and both dispatch tables with random data
    for (int i = 0; i < DEPTH; i++) load(2'd0, 6'(i), mk(int'($urandom), int'($urandom), 0));
    for (int i = 0; i < DEPTH; i++) load(2'd1, 6'(i), WD'($urandom));
    for (int i = 0; i < DEPTH; i++) load(2'd2, 6'(i), WD'($urandom));

    // Reset then sequential
    load(2'd0, 6'd0, mk(1, 0, 0));
    load(2'd0, 6'd1, mk(2, 0, 0));
    load(2'd0, 6'd2, mk(3, 0, 0));
    check("rst_cmar", int'(cmar), 0);
    check("rst_sp",   int'(sp),   0);
    check("rst_ctrl", int'(ctrl), 1);
    rst_n = 1'b1;
    tick(); check("seq_cmar1", int'(cmar), 1); check("seq_ctrl2", int'(ctrl), 2);
    tick(); check("seq_cmar2", int'(cmar), 2); check("seq_ctrl3", int'(ctrl), 3);

    // DISP1, with a same-edge rewrite of the dispatched entry
    do_reset();
    load(2'd0, 6'd1, mk(17, 0, 2));
    load(2'd1, 6'h23, WD'(6'h10));
    opcode = 6'h23;
    rst_n  = 1'b1;
    tick(); check("disp1_pre", int'(cmar), 1);
    load(2'd1, 6'h23, WD'(6'h2A));
    check("disp1_old", int'(cmar), 'h10);

    // DISP2
    do_reset();
    load(2'd0, 6'd1, mk(18, 0, 3));
    load(2'd2, 6'h23, WD'(6'h18));
    rst_n = 1'b1;
    tick(); tick(); check("disp2", int'(cmar), 'h18);

    // BRZ taken / not taken
    do_reset();
    load(2'd0, 6'd0, mk(5, 5, 4));
    load(2'd0, 6'd5, mk(6, 'h20, 5));
    zero = 1'b1; rst_n = 1'b1;
    tick(); check("brz_at5", int'(cmar), 5);
    tick(); check("brz_taken", int'(cmar), 'h20);
    do_reset();
    zero = 1'b0; rst_n = 1'b1;
    tick(); tick(); check("brz_fall", int'(cmar), 6);

    // NEXT wraps from the top address
    do_reset();
    load(2'd0, 6'd0, mk(7, 'h3F, 4));
    load(2'd0, 6'h3F, mk(8, 0, 0));
    rst_n = 1'b1;
    tick(); check("wrap_top", int'(cmar), 'h3F);
    tick(); check("wrap_zero", int'(cmar), 0);

    // CALL / RET
    do_reset();
    load(2'd0, 6'd0, mk(9, 4, 4));
    load(2'd0, 6'd4, mk(10, 'h30, 6));
    load(2'd0, 6'h30, mk(11, 0, 7));
    load(2'd0, 6'd5, mk(12, 0, 0));
    rst_n = 1'b1;
    tick();
    tick(); check("call_cmar", int'(cmar), 'h30); check("call_sp", int'(sp), 1);
    tick(); check("ret_cmar", int'(cmar), 5);     check("ret_sp", int'(sp), 0);

    // Nested calls overflow the stack
    do_reset();
    for (int k = 0; k < 4; k++) load(2'd0, 6'(k), mk(20 + k, k + 1, 6));
    load(2'd0, 6'd4, mk(24, 'h30, 6));
    rst_n = 1'b1;
    repeat (4) tick();
    check("nest_sp4", int'(sp), 4); check("nest_err0", int'(err), 0);
    tick();
    check("ovf_err", int'(err), 1); check("ovf_sp", int'(sp), 4); check("ovf_cmar", int'(cmar), 4);
    tick();
    check("ovf_frozen", int'(cmar), 4);

    // Asynchronous reset between edges clears the error immediately
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_cmar", int'(cmar), 0);
    check("async_err",  int'(err),  0);
    check("async_sp",   int'(sp),   0);

    // RET on an empty stack
    load(2'd0, 6'd0, mk(25, 0, 7));
    rst_n = 1'b1;
    tick(); check("uflow_err", int'(err), 1); check("uflow_cmar", int'(cmar), 0);

    // Stall holds the sequencer
    do_reset();
    load(2'd0, 6'd0, mk(26, 7, 4));
    load(2'd0, 6'd7, mk(27, 0, 0));
    rst_n = 1'b1;
    tick(); check("stall_at7", int'(cmar), 7);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); check("stall_cmar", int'(cmar), 7); check("stall_ctrl", int'(ctrl), 27);
    end
    stall = 1'b0;
    tick(); check("stall_release", int'(cmar), 8);

    // Live reload of the current word; uc_sel = 3 is ignored
    do_reset();
    load(2'd0, 6'd0, mk(28, 3, 4));
    load(2'd0, 6'd3, mk(29, 0, 0));
    rst_n = 1'b1;
    tick(); check("live_at3", int'(cmar), 3);
    stall = 1'b1;
    load(2'd0, 6'd3, mk('hABCDEF, 0, 0));
    check("live_ctrl", int'(ctrl), 'hABCDEF);
    load(2'd3, 6'd3, mk(1, 1, 1));
    check("sel3_ctrl", int'(ctrl), 'hABCDEF);
    check("sel3_cmar", int'(cmar), 3);
    stall = 1'b0;
    tick(); check("live_next", int'(cmar), 4);

    // Randomized phase: random microcode, inputs, loads and resets
    do_reset();
    for (int i = 0; i < DEPTH; i++) load(2'd0, 6'(i), WD'({$urandom, $urandom}));
    rst_n = 1'b1;
    for (int n = 0; n < 500; n++) begin
      opcode = 6'($urandom);
      zero   = 1'($urandom);
      stall  = ($urandom_range(0, 3) == 0);
      rst_n  = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 7) == 0) begin
        uc_we    = 1'b1;
        uc_sel   = 2'($urandom);
        uc_addr  = 6'($urandom);
        uc_wdata = WD'({$urandom, $urandom});
      end else begin
        uc_we = 1'b0;
      end
      tick();
    end
    uc_we = 1'b0; stall = 1'b0; rst_n = 1'b1;

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cu_micro_seq.md
Name: cu_micro_seq

Overview:
- Parametrised microprogram sequencer and control store for the multi-cycle CPU; the next generation of the existing microprogrammed control unit.
- Holds the control-store address register (CMAR), the control store and two opcode dispatch tables, plus a microsubroutine return stack.
- Adds a stall input, conditional microbranch, micro call/return, a runtime microcode load port and an asynchronous reset.
- Sits between the instruction register / ALU zero flag and the datapath control lines.

Parameters:
- AW, 6: control-store address width; depth 2^AW.
- CTRL_W, 24: width of the datapath control field.
- OP_W, 6: opcode width; each dispatch table has 2^OP_W entries.
- STK_D, 4: return-stack depth (1..8).
- RESET_ADDR, 0: CMAR value after reset and target of FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  current instruction opcode, indexes the dispatch tables.
- zero  in  1  ALU zero flag, used by BRZ.
- stall  in  1  1 = hold CMAR and the stack (for example, memory not ready).
- uc_we  in  1  microcode load write enable.
- uc_sel  in  2  load target: 0 = control store, 1 = dispatch1, 2 = dispatch2, 3 = ignored.
- uc_addr  in  max(AW,OP_W)  load address.
- uc_wdata  in  CTRL_W+AW+3  load data; dispatch entries use bits [AW-1:0].
- ctrl  out  CTRL_W  control field of the current microinstruction.
- cmar  out  AW  current micro-address.
- sp  out  4  return-stack occupancy.
- err  out  1  sticky stack error.

Behaviour:
- Microword layout: {ctrl[CTRL_W-1:0], target[AW-1:0], seq[2:0]}. The store word is the word at store[cmar].
- ctrl is combinational from store[cmar]; there is no extra latency.
- Reset (rst_n low, asynchronous): cmar = RESET_ADDR, sp = 0, err = 0.
  - ctrl reflects store[RESET_ADDR].
  - Store and tables are not reset; they retain their contents.
- Reset deasserted mid-program: execution restarts at RESET_ADDR and the stack is empty.
- Each rising edge with stall = 0 and err = 0 updates cmar according to seq:
  - 0 NEXT: cmar+1, modulo 2^AW (wraps to 0).
  - 1 FETCH: RESET_ADDR.
  - 2 DISP1: dispatch1[opcode].
  - 3 DISP2: dispatch2[opcode].
  - 4 JUMP: target.
  - 5 BRZ: zero ? target : cmar+1.
  - 6 CALL: push cmar+1, sp++, cmar = target.
  - 7 RET: pop into cmar, sp--.
- Boundary conditions:
  - CALL with sp = STK_D: no push, err set, cmar holds.
  - RET with sp = 0: err set, cmar = RESET_ADDR.
- err is sticky until reset. While err = 1, cmar and the stack freeze; ctrl keeps showing the frozen word.
- stall = 1: cmar, sp and the stack hold; ctrl is unchanged. stall has no effect on the load port.
- Load port: on a rising edge with uc_we = 1, the selected array at uc_addr is written.
  - Addresses are truncated to the array's width.
  - Writes proceed regardless of stall or err.
  - If the word written is store[cmar], ctrl shows the new value after that edge.
  - A write and a sequencer read of the same dispatch entry in the same edge: the sequencer uses the old value.
- Sequencer and load port may act in the same cycle.

Test Plan:
- Reset then sequential: load store[0..2] with seq = NEXT and ctrl = 0x000001, 0x000002, 0x000003; release rst_n. Required: cmar = 0,1,2 on successive edges; ctrl = 1,2,3.
- Dispatch: store[1].seq = DISP1, dispatch1[0x23] = 0x10 (lw), opcode = 0x23. Required: cmar goes 1 → 0x10.
  - Repeat with DISP2 and dispatch2[0x23] = 0x18. Required: cmar = 0x18.
- BRZ: store[5] = BRZ with target 0x20.
  - zero = 1: cmar goes 5 → 0x20.
  - zero = 0: cmar goes 5 → 6.
  - NEXT at address 0x3F: cmar wraps to 0.
- Call/return: CALL 0x30 at address 4, RET at 0x30. Required: cmar 4 → 0x30 (sp = 1) → 5 (sp = 0).
  - Five nested CALLs with STK_D = 4: err = 1 after the fifth CALL, sp = 4, cmar frozen.
  - RET with sp = 0: err = 1, cmar = 0.
- Stall and async reset: hold stall = 1 for 3 cycles at cmar = 7. Required: cmar stays 7, ctrl unchanged.
  - Pulse rst_n low between clock edges: cmar = 0 and err = 0 immediately, without waiting for a clock edge.
- Live reload: while cmar = 3, write store[3] ctrl = 0xABCDEF. Required: ctrl = 0xABCDEF after that edge.
  - A uc_sel = 3 write changes nothing.
